// File: rtl/fpm_pkg.sv
// Shared definitions for the binary32 multiplier normalise/round stage.
// Holds the exponent constants, the canonical quiet NaN, the result flag bit
// positions and the stage-1 pipeline word.
package fpm_pkg;

   localparam int unsigned BIAS        = 127;
   localparam int unsigned EXP_MAX     = 255;
   localparam logic [31:0] QNAN        = 32'h7FC0_0000;

   localparam int unsigned FRAC_W      = 23;  // stored fraction, hidden bit dropped
   localparam int unsigned EXP_FIELD_W = 8;   // packed exponent field
   localparam int unsigned SEXP_W      = 12;  // signed working exponent, room for +2

   // out_flags = {overflow, underflow, inexact}
   localparam int unsigned FLAGS_W     = 3;
   localparam int unsigned FLAG_OVF    = 2;
   localparam int unsigned FLAG_UNF    = 1;
   localparam int unsigned FLAG_INX    = 0;

   typedef struct packed {
      logic              sign;
      logic [SEXP_W-1:0] exp;   // two's complement
      logic [FRAC_W-1:0] frac;
      logic              g;
      logic              r;
      logic              s;
      logic              nan;
      logic              inf;
      logic              zero;
   } s1_t;

endpackage

// File: rtl/fpm_round_rne.sv
// Rounding increment for the normalised fraction.
// With FPM_RNE_ROUND_EN defined it rounds to nearest, ties to even; otherwise
// it truncates (round toward zero). Inexact is reported from G|R|S either way.
// Ports:
//   frac_i    : normalised fraction (hidden bit dropped)
//   g_i/r_i/s_i : guard, round and sticky bits below the fraction lsb
//   frac_o    : rounded fraction
//   carry_o   : rounding carried out of the fraction (exponent must bump)
//   inexact_o : discarded bits were non-zero
module fpm_round_rne
   import fpm_pkg::*;
(
   input  logic [FRAC_W-1:0] frac_i,
   input  logic              g_i,
   input  logic              r_i,
   input  logic              s_i,
   output logic [FRAC_W-1:0] frac_o,
   output logic              carry_o,
   output logic              inexact_o
);

   logic inc;

   always_comb begin
`ifdef FPM_RNE_ROUND_EN
      inc = g_i & (r_i | s_i | frac_i[0]);
`else
      inc = 1'b0;
`endif
      {carry_o, frac_o} = {1'b0, frac_i} + {{FRAC_W{1'b0}}, inc};
      inexact_o         = g_i | r_i | s_i;
   end

endmodule

// File: rtl/fpm_norm_round.sv
// Normalise / round / pack stage of a pipelined binary32 multiplier, sitting
// behind the 24x24 mantissa multiplier. Two register stages with valid/ready
// flow control; a downstream stall freezes both stages.
// Build option: FPM_RNE_ROUND_EN selects round-to-nearest-even, otherwise the
// stage truncates and saturates overflow to the largest finite value.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_sign, in_exp     : result sign, biased exponent sum (signed)
//   in_mant             : 2*MANT_W-bit significand product
//   in_nan/in_inf/in_zero : special-case flags resolved upstream
//   out_valid/out_ready : downstream handshake
//   out_result          : packed binary32
//   out_flags           : {overflow, underflow, inexact}
module fpm_norm_round
   import fpm_pkg::*;
#(
   parameter int unsigned MANT_W = 24,
   parameter int unsigned EXP_W  = 10,
   parameter int unsigned BIAS   = fpm_pkg::BIAS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sign,
   input  logic [EXP_W-1:0]      in_exp,
   input  logic [2*MANT_W-1:0]   in_mant,
   input  logic                  in_nan,
   input  logic                  in_inf,
   input  logic                  in_zero,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_result,
   output logic [FLAGS_W-1:0]    out_flags
);

   localparam int unsigned ProdW = 2 * MANT_W;
   localparam logic signed [SEXP_W-1:0] ExpLimit = SEXP_W'(2 * BIAS + 1);
   localparam logic signed [SEXP_W-1:0] ExpZero  = '0;
   localparam logic [EXP_FIELD_W-1:0]   ExpInf   = EXP_FIELD_W'(EXP_MAX);
`ifndef FPM_RNE_ROUND_EN
   localparam logic [EXP_FIELD_W-1:0]   ExpSat   = EXP_FIELD_W'(EXP_MAX - 1);
`endif

   logic                     stall;
   s1_t                      s1_d, s1_q;
   logic                     v1_q, v2_q;
   logic [31:0]              result_d, result_q;
   logic [FLAGS_W-1:0]       flags_d, flags_q;

   logic [FRAC_W-1:0]        frac_rnd;
   logic                     carry;
   logic                     inexact;
   logic signed [SEXP_W-1:0] exp_fin;

   assign stall    = v2_q & ~out_ready;
   assign in_ready = ~stall;

   // Stage 1: the product of two 1.x significands lies in [1,4), so at most a
   // one-bit right shift is needed.
   always_comb begin
      s1_d      = '0;
      s1_d.sign = in_sign;
      s1_d.nan  = in_nan;
      s1_d.inf  = in_inf;
      s1_d.zero = in_zero;
      if (in_mant[ProdW-1]) begin
         s1_d.frac = in_mant[ProdW-2 -: FRAC_W];
         s1_d.g    = in_mant[ProdW-2-FRAC_W];
         s1_d.r    = in_mant[ProdW-3-FRAC_W];
         s1_d.s    = |in_mant[ProdW-4-FRAC_W:0];
      end else begin
         s1_d.frac = in_mant[ProdW-3 -: FRAC_W];
         s1_d.g    = in_mant[ProdW-3-FRAC_W];
         s1_d.r    = in_mant[ProdW-4-FRAC_W];
         s1_d.s    = |in_mant[ProdW-5-FRAC_W:0];
      end
      s1_d.exp = SEXP_W'($signed(in_exp)) + SEXP_W'(in_mant[ProdW-1]);
   end

   fpm_round_rne u_round (
      .frac_i    (s1_q.frac),
      .g_i       (s1_q.g),
      .r_i       (s1_q.r),
      .s_i       (s1_q.s),
      .frac_o    (frac_rnd),
      .carry_o   (carry),
      .inexact_o (inexact)
   );

   // Stage 2: apply the rounding carry, range-check and pack. Specials win
   // over the arithmetic result and report no flags.
   always_comb begin
      exp_fin  = s1_q.exp + SEXP_W'(carry);
      result_d = '0;
      flags_d  = '0;
      if (s1_q.nan) begin
         result_d = QNAN;
      end else if (s1_q.inf) begin
         result_d = {s1_q.sign, ExpInf, {FRAC_W{1'b0}}};
      end else if (s1_q.zero) begin
         result_d = {s1_q.sign, 31'b0};
      end else if (exp_fin >= ExpLimit) begin
`ifdef FPM_RNE_ROUND_EN
         result_d = {s1_q.sign, ExpInf, {FRAC_W{1'b0}}};
`else
         result_d = {s1_q.sign, ExpSat, {FRAC_W{1'b1}}};
`endif
         flags_d[FLAG_OVF] = 1'b1;
         flags_d[FLAG_INX] = 1'b1;
      end else if (exp_fin <= ExpZero) begin
         // No subnormal output: flush to signed zero.
         result_d          = {s1_q.sign, 31'b0};
         flags_d[FLAG_UNF] = 1'b1;
         flags_d[FLAG_INX] = 1'b1;
      end else begin
         result_d          = {s1_q.sign, exp_fin[EXP_FIELD_W-1:0], frac_rnd};
         flags_d[FLAG_INX] = inexact;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q     <= 1'b0;
         s1_q     <= '0;
         v2_q     <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else if (!stall) begin
         v1_q <= in_valid;
         if (in_valid) begin
            s1_q <= s1_d;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            result_q <= result_d;
            flags_q  <= flags_d;
         end
      end
   end

   assign out_valid  = v2_q;
   assign out_result = result_q;
   assign out_flags  = flags_q;

endmodule

// File: tb/tb_fpm_norm_round.sv
// Scoreboard bench for fpm_norm_round: expected {flags,result} words are queued
// as each input is accepted and compared as each output is taken.
module tb_fpm_norm_round;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [9:0]  in_exp = '0;
   logic [47:0] in_mant = '0;
   logic        in_nan = 1'b0;
   logic        in_inf = 1'b0;
   logic        in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;

   logic        ready_ctl = 1'b1;
   logic        bp_rand = 1'b0;
   logic        rnd_ready = 1'b1;

   int          n_total = 0;
   int          n_bad = 0;
   int          n_acc = 0;
   logic [34:0] sb_q[$];
   logic [34:0] mon_want;
   logic [34:0] held;

   assign out_ready = bp_rand ? rnd_ready : ready_ctl;

   always #5 clk = ~clk;

   fpm_norm_round dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .in_nan     (in_nan),
      .in_inf     (in_inf),
      .in_zero    (in_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Reference: normalise by shifting and round from the whole remainder.
   function automatic logic [34:0] model(input logic s, input int e, input logic [47:0] m,
                                         input logic nan, input logic inf, input logic zero);
      logic [47:0] q, rem, half;
      int          sh, ex;
      logic        inx;
      if (nan)  return {3'b000, 32'h7FC0_0000};
      if (inf)  return {3'b000, s, 8'hFF, 23'h0};
      if (zero) return {3'b000, s, 31'h0};
      sh   = m[47] ? 24 : 23;
      ex   = e + (m[47] ? 1 : 0);
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 48'd1 << (sh - 1);
      inx  = (rem != 0);
`ifdef FPM_RNE_ROUND_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin
         q  = q >> 1;
         ex = ex + 1;
      end
      if (ex >= 255) return {3'b101, s, 8'hFF, 23'h0};
`else
      if (ex >= 255) return {3'b101, s, 8'hFE, 23'h7F_FFFF};
`endif
      if (ex <= 0) return {3'b011, s, 31'h0};
      return {2'b00, inx, s, 8'(ex), q[22:0]};
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic s, input int e, input logic [47:0] m, input logic nan,
                       input logic inf, input logic zero, input logic [34:0] want);
      logic acc;
      logic done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = 10'(e);
      in_mant  = m;
      in_nan   = nan;
      in_inf   = inf;
      in_zero  = zero;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) sb_q.push_back(want);
         @(posedge clk);
         #1;
         if (acc) begin
            n_acc++;
            done = 1'b1;
         end
      end
      if (!done) check_val("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic s, input int e, input logic [47:0] m, input logic nan,
                         input logic inf, input logic zero);
      send(s, e, m, nan, inf, zero, model(s, e, m, nan, inf, zero));
   endtask

   task automatic wait_drain();
      int i = 0;
      while (sb_q.size() != 0 && i < 200) begin
         @(posedge clk);
         i++;
      end
      check_val("drain", 64'(sb_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_val("extra_out", {32'd0, out_result}, 64'hDEAD);
         end else begin
            mon_want = sb_q.pop_front();
            check_val("result", 64'(out_result), 64'(mon_want[31:0]));
            check_val("flags", 64'(out_flags), 64'(mon_want[34:32]));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] m;
      int          e;
      int          r;

      #2;
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_result", 64'(out_result), 64'd0);
      check_val("rst_flags", 64'(out_flags), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      check_val("rst_inready", 64'(in_ready), 64'd1);

      // 19.0 * 15.0 with latency check
      send(1'b0, 134, 48'h8E80_0000_0000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h438E_8000});
      @(negedge clk);
      check_val("lat_1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check_val("lat_2", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;

      send(1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h4010_0000});
`ifdef FPM_RNE_ROUND_EN
      send(1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, {3'b001, 32'h4000_0000});
      send(1'b0, 254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, {3'b101, 32'h7F80_0000});
      send(1'b0, 253, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, {3'b101, 32'h7F80_0000});
`else
      send(1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, {3'b001, 32'h3FFF_FFFF});
      send(1'b0, 254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, {3'b101, 32'h7F7F_FFFF});
      send(1'b0, 253, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, {3'b001, 32'h7F7F_FFFF});
`endif
      send(1'b1, 0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, {3'b011, 32'h8000_0000});
      send(1'b0, 1, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h0080_0000});
      send(1'b0, -1, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, {3'b011, 32'h0000_0000});
      send(1'b1, 130, 48'h9000_0000_0000, 1'b1, 1'b1, 1'b0, {3'b000, 32'h7FC0_0000});
      send(1'b1, 130, 48'h9000_0000_0000, 1'b0, 1'b1, 1'b1, {3'b000, 32'hFF80_0000});
      send(1'b0, 130, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b1, {3'b000, 32'h0000_0000});
      wait_drain();

      // Backpressure: three words against a stalled output
      ready_ctl = 1'b0;
      n_acc     = 0;
      fork
         begin
            send_m(1'b0, 130, 48'hC123_4567_89AB, 1'b0, 1'b0, 1'b0);
            send_m(1'b1, 100, 48'h5555_5555_5555, 1'b0, 1'b0, 1'b0);
            send_m(1'b0, 140, 48'hA000_0080_0001, 1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            check_val("bp_accepted", 64'(n_acc), 64'd2);
            check_val("bp_inready", 64'(in_ready), 64'd0);
            check_val("bp_valid", 64'(out_valid), 64'd1);
            held = {out_flags, out_result};
            repeat (2) begin
               @(negedge clk);
               check_val("bp_hold", 64'({out_flags, out_result}), 64'(held));
            end
            @(posedge clk);
            #1;
            ready_ctl = 1'b1;
         end
      join
      wait_drain();

      // Random legal traffic with random downstream stalls
      bp_rand = 1'b1;
      for (int k = 0; k < 60; k++) begin
         m = {16'($urandom()), 32'($urandom())};
         if (m[47:46] == 2'b00) m[46] = 1'b1;
         e = int'($urandom_range(0, 300)) - 20;
         r = int'($urandom_range(0, 15));
         send_m(1'($urandom()), e, m, r == 0 || r == 3, r == 1 || r == 3, r == 2 || r == 3);
      end
      wait_drain();
      bp_rand = 1'b0;
      @(posedge clk);
      #1;

      // Reset while stalled discards both in-flight words
      ready_ctl = 1'b0;
      send_m(1'b0, 120, 48'h8800_0000_0000, 1'b0, 1'b0, 1'b0);
      send_m(1'b0, 121, 48'h8800_0000_0000, 1'b0, 1'b0, 1'b0);
      check_val("rs_pre_valid", 64'(out_valid), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check_val("rs_valid", 64'(out_valid), 64'd0);
      check_val("rs_result", 64'(out_result), 64'd0);
      check_val("rs_flags", 64'(out_flags), 64'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      ready_ctl = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_val("rs_quiet", 64'(out_valid), 64'd0);
      end
      check_val("rs_inready", 64'(in_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fpm_norm_round.md
Name: fpm_norm_round

Overview:
- Pipelined single-precision FP multiplier stage sitting directly downstream of the 24x24 Wallace mantissa multiplier.
- Consumes the 48-bit mantissa product, the pre-biased exponent sum, the sign and the special-case flags.
- Normalises, rounds and packs an IEEE-754 binary32 result.
- Two register stages with valid/ready flow control, so the Wallace stage can be stalled.

Parameters:
- MANT_W, 24, significand width including hidden bit (product width 2*MANT_W).
- EXP_W, 10, signed width of the incoming exponent sum.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept this cycle
- in_sign  input  1  sign_a XOR sign_b
- in_exp  input  EXP_W  signed, ea+eb-BIAS (range -127..383)
- in_mant  input  2*MANT_W  unsigned product of two 1.23 significands
- in_nan  input  1  operand NaN or inf*0 (resolved upstream)
- in_inf  input  1  an operand is infinite
- in_zero  input  1  an operand is zero or denormal
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  packed binary32
- out_flags  output  3  {overflow, underflow, inexact}

Behaviour:
- Reset (rst=0, async): all valid bits 0, out_result 0x00000000, out_flags 0. in_ready=1 once rst=1. Reset mid-operation discards both in-flight words with no partial output.
- Handshake: transfer on valid&&ready at each side.
  - stall = out_valid && !out_ready; stall freezes both stages.
  - in_ready = !stall.
  - out_result/out_flags hold stable while out_valid && !out_ready.
- Latency 2 cycles from accepted input to out_valid with no stall; throughput 1/cycle.
- Stage 1 (normalise):
  - If in_mant[47]=1: frac=in_mant[46:24], guard=[23], round=[22], sticky=|[21:0], exp=in_exp+1.
  - Else: frac=[45:23], guard=[22], round=[21], sticky=|[20:0], exp=in_exp.
  - Register sign, exp, frac, G/R/S and special flags.
- Stage 2 (round/pack):
  - RNE: inc = G && (R || S || frac[0]).
  - {carry,frac'}=frac+inc; carry=1 gives frac'=0 and exp+1.
  - inexact = G|R|S.
- Range rules on the final exponent:
  - exp >= 255: result {sign,0xFF,0}, overflow=1, inexact=1.
  - exp <= 0: flush to signed zero {sign,0,0}, underflow=1, inexact=1. No denormal output.
- Specials override arithmetic, priority nan > inf > zero; all flags 0 on specials.
  - nan: 0x7FC00000.
  - inf: {sign,0xFF,0}.
  - zero: {sign,31'b0}.
- in_mant[47:46]==0 with no special flag set is illegal upstream behaviour; output is unspecified but out_valid still follows the handshake.

Optional Feature:
- FPM_RNE_ROUND_EN defined: round-to-nearest-even as above.
- Undefined: truncation (round toward zero). inc=0, overflow saturates to {sign,0xFE,0x7FFFFF} with overflow=1. inexact is still reported from G|R|S.

Decomposition:
- Shared package fpm_pkg holds:
  - BIAS, EXP_MAX=255, QNAN=32'h7FC00000.
  - A stage-1 struct/typedef {sign, exp, frac, g, r, s, nan, inf, zero}.
  - The flag bit indices.
- One sub-module fpm_round_rne: combinational rounding increment, carry and inexact. It is swapped for truncation under the macro.

Test Plan:
- 19.0*15.0: in_sign 0, in_exp 134, in_mant 0x8E8000000000 -> out_result 0x438E8000 after 2 cycles, flags 000.
- 1.5*1.5: in_exp 127, in_mant 0x900000000000 -> 0x40100000, flags 000.
- Rounding tie, lsb odd: in_exp 127, in_mant 0x7FFFFFC00000.
  - With FPM_RNE_ROUND_EN: 0x40000000, inexact=1.
  - Without the macro: 0x3FFFFFFF, inexact=1.
- Range limits:
  - Overflow: in_exp 254, in_mant 0x800000000000 -> 0x7F800000, flags 101.
  - Underflow: in_exp 0, in_mant 0x400000000000, sign 1 -> 0x80000000, flags 011.
- Specials: in_nan=1 with in_inf=1 -> 0x7FC00000. in_inf only, sign 1 -> 0xFF800000. in_zero only -> 0x00000000.
- Backpressure: issue 3 back-to-back words with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, output held stable, all 3 results then emerge in order with no loss. Assert rst=0 mid-stall -> out_valid=0 immediately.
